// File: rtl/hermes_pkg.sv
// HermesPkg: port identifiers of a Hermes router.
package HermesPkg;
    typedef enum logic [2:0] {EAST, WEST, NORTH, SOUTH, LOCAL} hermes_port_t;
endpackage

// File: rtl/traffic_log_arbiter_pkg.sv
// TrafficLogPkg: completed-message record shared by monitors and the log writer.
package TrafficLogPkg;
    import HermesPkg::*;
    typedef struct packed {
        logic [63:0]  header_time;
        logic [15:0]  address;
        logic [31:0]  service;
        logic [31:0]  size;
        logic [63:0]  bw_alloc;
        hermes_port_t port;
        logic [15:0]  target;
        logic [15:0]  task_id;
        logic [15:0]  cons_id;
        logic         has_task;
        logic         has_cons;
    } traffic_rec_t;
    localparam int TRAFFIC_REC_W = $bits(traffic_rec_t);
endpackage

// File: rtl/traffic_log_arbiter_if.sv
// traffic_log_arbiter_if: requester-side and writer-side record handshakes.
interface traffic_log_arbiter_if #(parameter int NUM_REQ = 5);
    import TrafficLogPkg::*;
    logic         [NUM_REQ-1:0] req_valid_i;
    traffic_rec_t [NUM_REQ-1:0] req_rec_i;
    logic         [NUM_REQ-1:0] req_ready_o;
    logic                       log_valid_o;
    traffic_rec_t               log_rec_o;
    logic                       log_ready_i;
    modport master (output req_valid_i, req_rec_i, log_ready_i, input req_ready_o, log_valid_o, log_rec_o);
    modport slave  (input req_valid_i, req_rec_i, log_ready_i, output req_ready_o, log_valid_o, log_rec_o);
endinterface

// File: rtl/traffic_log_arbiter_fifo.sv
// traffic_log_fifo: synchronous FIFO; head reads as zero while empty.
module traffic_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign level_d = (do_push && !do_pop) ? level_q + 1'b1 : (do_pop && !do_push) ? level_q - 1'b1 : level_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q    <= do_pop ? rd_q + 1'b1 : rd_q;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign level_o = level_q;
endmodule

// File: rtl/traffic_log_arbiter.sv
// traffic_log_arbiter: round-robin merge of monitor records into one buffered log stream.
module traffic_log_arbiter import TrafficLogPkg::*; #(
    parameter int NUM_REQ    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    traffic_log_arbiter_if.slave        bus,
    output logic [CNT_WIDTH-1:0]        fwd_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0]        rr_q, rr_d, gnt_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 found, can_push, pop, full, empty;
    int                   j;
    traffic_rec_t         head;
    always_comb begin
        found   = 1'b0;
        gnt_idx = rr_q;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(rr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid_i[j]) begin
                found   = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end
    // a full FIFO still takes a record when the writer drains the head this cycle
    assign pop             = bus.log_valid_o && bus.log_ready_i;
    assign can_push        = !full || pop;
    assign gnt             = (found && can_push && !rst_i) ? NUM_REQ'(1) << gnt_idx : '0;
    assign bus.req_ready_o = gnt;
    assign rr_d            = (gnt == '0) ? rr_q : (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
    assign cnt_d           = (pop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
        end
    end
    traffic_log_fifo #(.WIDTH(TRAFFIC_REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (|gnt),
        .data_i  (bus.req_rec_i[gnt_idx]),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level_o)
    );
    assign bus.log_valid_o = !empty && !rst_i;
    assign bus.log_rec_o   = head;
    assign fwd_cnt_o       = cnt_q;
endmodule

// File: tb/tb_traffic_log_arbiter.sv
// tb_traffic_log_arbiter: directed stimulus with a record scoreboard and cycle reference model.
module tb_traffic_log_arbiter;
    import HermesPkg::*;
    import TrafficLogPkg::*;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    traffic_log_arbiter_if #(.NUM_REQ(5)) bus ();
    traffic_log_arbiter_if #(.NUM_REQ(5)) bus2 ();
    logic [31:0] fwd;
    logic [3:0]  level, fwd2, level2;
    traffic_log_arbiter dut (.clk_i(clk), .rst_i(rst), .bus(bus), .fwd_cnt_o(fwd), .fifo_level_o(level));
    traffic_log_arbiter #(.CNT_WIDTH(4)) dut_sat (.clk_i(clk), .rst_i(rst), .bus(bus2), .fwd_cnt_o(fwd2), .fifo_level_o(level2));

    int           n_chk = 0, n_pass = 0;
    traffic_rec_t exp_q[$];
    traffic_rec_t mon_e;
    int           seqs[5];
    bit           hold[5];
    int           m_level, m_ptr, m_gcnt, pops;
    longint       m_cnt;

    function automatic traffic_rec_t mk(int p, int s);
        traffic_rec_t r;
        r.header_time = {32'hC0DE_0000 | 32'(p), 32'(s)};
        r.address     = 16'h1000 + 16'(p);
        r.service     = 32'(s);
        r.size        = 32'(s * 4);
        r.bw_alloc    = ~r.header_time;
        r.port        = hermes_port_t'(p);
        r.target      = 16'(s + p);
        r.task_id     = 16'(s);
        r.cons_id     = 16'(p * 7);
        r.has_task    = s[0];
        r.has_cons    = p[0];
        return r;
    endfunction

    task automatic chk(input string n, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    endtask

    always @(negedge clk) begin
        if (bus.log_valid_o && bus.log_ready_i) begin
            n_chk++;
            if (exp_q.size() == 0) $display("FAIL rec_unexpected: got %h, expected none", bus.log_rec_o);
            else begin
                mon_e = exp_q.pop_front();
                if (bus.log_rec_o == mon_e) n_pass++;
                else $display("FAIL rec_order: got %h, expected %h", bus.log_rec_o, mon_e);
            end
        end
    end

    task automatic req(input int i, input int s, input bit h);
        seqs[i] = s;
        bus.req_rec_i[i] = mk(i, s);
        bus.req_valid_i[i] = 1'b1;
        hold[i] = h;
    endtask

    // one clock: compare against the reference model, then let granted requesters advance
    task automatic cycle(input int hg, input int hl);
        logic [4:0] g;
        int gi;
        bit p;
        @(negedge clk);
        p = (m_level != 0) && bus.log_ready_i;
        gi = -1;
        if (m_level < 8 || p)
            for (int k = 0; k < 5; k++)
                if (gi < 0 && bus.req_valid_i[(m_ptr + k) % 5]) gi = (m_ptr + k) % 5;
        g = (gi < 0) ? 5'b0 : 5'(1 << gi);
        chk("grant", bus.req_ready_o, g);
        if (hg >= 0) chk("grant_directed", bus.req_ready_o, hg);
        chk("level", level, m_level);
        if (hl >= 0) chk("level_directed", level, hl);
        chk("log_valid", bus.log_valid_o, m_level != 0);
        chk("fwd_cnt", fwd, m_cnt);
        if (gi >= 0) begin
            exp_q.push_back(mk(gi, seqs[gi]));
            m_ptr = (gi + 1) % 5;
            m_gcnt++;
        end
        m_level = m_level + (gi >= 0 ? 1 : 0) - (p ? 1 : 0);
        if (p && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        @(posedge clk); #1;
        if (gi >= 0) begin
            seqs[gi]++;
            bus.req_rec_i[gi] = mk(gi, seqs[gi]);
            if (!hold[gi]) bus.req_valid_i[gi] = 1'b0;
        end
    endtask

    task automatic do_reset(input int hl);
        rst = 1'b1;
        @(negedge clk);
        if (hl >= 0) chk("level_pre_reset", level, hl);
        chk("grant_in_reset", bus.req_ready_o, 0);
        chk("log_valid_in_reset", bus.log_valid_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_level = 0;
        m_ptr = 0;
        m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic drain();
        bus.log_ready_i = 1'b1;
        for (int k = 0; k < 40 && (m_level != 0 || bus.req_valid_i != 0); k++) cycle(-1, -1);
        @(negedge clk);
        chk("level_drained", level, 0);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.req_rec_i = '0;
        bus.log_ready_i = 1'b0;
        bus2.req_valid_i = '0;
        bus2.req_rec_i = '0;
        bus2.log_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) hold[i] = 1'b0;
        m_gcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(-1);
        @(negedge clk);
        chk("reset_log_valid", bus.log_valid_o, 0);
        chk("reset_log_rec", |bus.log_rec_o, 0);
        chk("reset_fwd", fwd, 0);
        chk("reset_level", level, 0);
        chk("reset_grant", bus.req_ready_o, 0);
        @(posedge clk); #1;

        bus.log_ready_i = 1'b1;
        req(2, 'h10, 1'b0);
        cycle(5'b00100, 0);
        cycle(0, 1);
        cycle(0, 0);
        @(negedge clk);
        chk("single_fwd", fwd, 1);
        @(posedge clk); #1;

        do_reset(-1);
        for (int i = 0; i < 5; i++) req(i, 'h200 + i * 16, 1'b1);
        bus.log_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) cycle(1 << (k % 5), -1);
        for (int i = 0; i < 5; i++) hold[i] = 1'b0;
        drain();

        bus.log_ready_i = 1'b0;
        req(1, 'h300, 1'b1);
        for (int k = 0; k < 8; k++) cycle(5'b00010, k);
        cycle(0, 8);
        bus.log_ready_i = 1'b1;
        cycle(5'b00010, 8);
        hold[1] = 1'b0;
        cycle(5'b00010, 8);
        drain();

        do_reset(-1);
        m_gcnt = 0;
        req(0, 'h400, 1'b1);
        req(3, 'h430, 1'b1);
        for (int k = 0; k < 300 && bus.req_valid_i != 0; k++) begin
            bus.log_ready_i = 1'($urandom_range(0, 1));
            cycle(-1, -1);
            if (m_gcnt >= 18) begin
                hold[0] = 1'b0;
                hold[3] = 1'b0;
            end
        end
        drain();
        @(negedge clk);
        chk("wrap_fwd", fwd, 20);
        @(posedge clk); #1;

        bus.log_ready_i = 1'b0;
        req(1, 'h500, 1'b1);
        req(2, 'h520, 1'b1);
        for (int k = 0; k < 5; k++) cycle((k % 2 == 0) ? 5'b00010 : 5'b00100, k);
        do_reset(5);
        cycle(5'b00010, 0);
        hold[1] = 1'b0;
        hold[2] = 1'b0;
        drain();

        bus2.log_ready_i = 1'b1;
        bus2.req_rec_i[0] = mk(0, 'h600);
        bus2.req_valid_i = 5'b00001;
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("sat_cnt", fwd2, (pops > 15) ? 15 : pops);
            if (bus2.log_valid_o && bus2.log_ready_i) pops++;
        end
        chk("sat_pops_ge_17", pops >= 17, 1);
        chk("sat_final", fwd2, 15);
        chk("sat_level", level2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
